// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: ROM read port, ID-stage valid/ready head port and branch redirect.
// master = fetch queue side, slave = ROM / decode side.
// Statistics outputs exist only when FETCH_STATS_EN is defined.
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_addr_i;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_ce_o;
  logic [DATA_W-1:0] rom_data_i;
  logic              id_ready_i;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;
`ifdef FETCH_STATS_EN
  logic [31:0]       fetch_cnt_o;
  logic [31:0]       flush_cnt_o;

  modport master (
    input  branch_flag_i, branch_addr_i, rom_data_i, id_ready_i,
    output rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o,
    output fetch_cnt_o, flush_cnt_o
  );
  modport slave (
    output branch_flag_i, branch_addr_i, rom_data_i, id_ready_i,
    input  rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o,
    input  fetch_cnt_o, flush_cnt_o
  );
`else
  modport master (
    input  branch_flag_i, branch_addr_i, rom_data_i, id_ready_i,
    output rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o
  );
  modport slave (
    output branch_flag_i, branch_addr_i, rom_data_i, id_ready_i,
    input  rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o
  );
`endif
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch stage: prefetches sequential ROM words into a DEPTH-entry {pc, inst} FIFO for ID.
// Latency: issue -> push 1 cycle -> id_valid 2 cycles after issue; branch target visible 3 cycles after branch.
// Backpressure: issue only while (count + inflight) < DEPTH, so a stalled ID never loses data.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
module if_fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst,
  if_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic flush;
  logic unused_addr_bits;

  assign flush = bus.branch_flag_i;
  // Credits are the registered occupancy plus the read already on its way back.
  assign issue = !rst && !flush &&
                 ((CW+1)'(count) + (CW+1)'(inflight) < (CW+1)'(DEPTH));
  assign push  = inflight && !flush;
  assign pop   = (count != '0) && bus.id_ready_i;

  assign bus.rom_ce_o   = issue;
  assign bus.rom_addr_o = fetch_pc;
  assign bus.id_valid_o = (count != '0);
  assign bus.id_pc_o    = (count != '0) ? mem_pc[rd_ptr]   : '0;
  assign bus.id_inst_o  = (count != '0) ? mem_inst[rd_ptr] : NOP;

  // Target low bits are dropped: fetches are always word aligned.
  assign unused_addr_bits = ^bus.branch_addr_i[1:0];

  // Fetch address and in-flight read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (flush) begin
      fetch_pc <= {bus.branch_addr_i[ADDR_W-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(4);
        inflight_pc <= fetch_pc;
      end
    end
  end

  // FIFO pointers and occupancy; a flush empties the queue after any same-cycle pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage: returned ROM word lands next to the pc it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= inflight_pc;
      mem_inst[wr_ptr] <= bus.rom_data_i;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
  logic        flush_hit;

  // A flush counts only if it threw away a queued entry or a returning read.
  assign flush_hit = flush && (((count - CW'(pop)) != '0) || inflight);

  // Saturating pop and useful-flush counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop && (fetch_cnt != 32'hFFFF_FFFF))       fetch_cnt <= fetch_cnt + 32'd1;
      if (flush_hit && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.fetch_cnt_o = fetch_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: vector table, directed corner sequences, randomized run
// against a queue-based reference model, and an address-wrap instance.
module tb_if_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  function automatic logic [31:0] rom_f(logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  // ROM models: data one cycle after an enabled read.
  always @(posedge clk) if (bus.rom_ce_o)  bus.rom_data_i  <= rom_f(bus.rom_addr_o);
  always @(posedge clk) if (bus2.rom_ce_o) bus2.rom_data_i <= rom_f(bus2.rom_addr_o);

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic br, input logic [31:0] ba, input logic rdy);
    @(negedge clk);
    bus.branch_flag_i = br;
    bus.branch_addr_i = ba;
    bus.id_ready_i    = rdy;
    #1;
  endtask

  task automatic expect_out(input string name, input logic ce, input logic [31:0] ra,
                            input logic vld, input logic [31:0] pc, input logic [31:0] inst);
    check(name, {30'd0, bus.rom_ce_o, bus.rom_addr_o, bus.id_valid_o, bus.id_pc_o, bus.id_inst_o},
                {30'd0, ce, ra, vld, pc, inst});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.branch_flag_i = 1'b0;
    bus.branch_addr_i = '0;
    bus.id_ready_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference model: a queue of delivered {pc,inst}, the next fetch address and one pending read.
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic        m_pend;
  logic [31:0] m_pend_pc;
  int          m_pops;
  int          m_flushes;

  task automatic model_step(input logic br, input logic [31:0] ba, input logic rdy, input string name);
    logic        e_ce, e_vld, pop;
    logic [31:0] e_pc, e_inst;
    int          sz;
    sz    = mq.size();
    e_vld = (sz > 0);
    e_pc  = e_vld ? mq[0].pc   : 32'h0;
    e_inst = e_vld ? mq[0].inst : NOP;
    e_ce  = !br && (sz + int'(m_pend) < 4);
    drive(br, ba, rdy);
    expect_out(name, e_ce, m_fpc, e_vld, e_pc, e_inst);
    pop = e_vld && rdy;
    if (pop) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (br) begin
      if (mq.size() > 0 || m_pend) m_flushes++;
      mq.delete();
      m_pend = 1'b0;
      m_fpc  = ba & 32'hFFFF_FFFC;
    end else begin
      if (m_pend) mq.push_back('{pc: m_pend_pc, inst: rom_f(m_pend_pc)});
      m_pend = e_ce;
      if (e_ce) begin
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end
    end
  endtask

  typedef struct {
    logic br; logic [31:0] ba; logic rdy;
    logic ce; logic [31:0] ra; logic vld; logic [31:0] pc; logic [31:0] inst;
  } vec_t;
  vec_t tbl[9];

  int issues;

  initial begin
    bus2.branch_flag_i = 1'b0;
    bus2.branch_addr_i = '0;
    bus2.id_ready_i    = 1'b1;
    bus.rom_data_i     = '0;
    bus2.rom_data_i    = '0;

    //            br  ba            rdy  ce  rom_addr       vld pc             inst
    tbl[0] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h000, 1'b0, 32'h000, NOP};
    tbl[1] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h004, 1'b0, 32'h000, NOP};
    tbl[2] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h008, 1'b1, 32'h000, 32'h100};
    tbl[3] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h00C, 1'b1, 32'h004, 32'h101};
    tbl[4] = '{1'b1, 32'h20B,   1'b1, 1'b0, 32'h010, 1'b1, 32'h008, 32'h102};
    tbl[5] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h208, 1'b0, 32'h000, NOP};
    tbl[6] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h20C, 1'b0, 32'h000, NOP};
    tbl[7] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h210, 1'b1, 32'h208, 32'h182};
    tbl[8] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h214, 1'b1, 32'h20C, 32'h183};

    // Reset values while held in reset.
    #2;
    expect_out("reset_state", 1'b0, 32'h0, 1'b0, 32'h0, NOP);

    // Streaming plus misaligned branch, from the table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].br, tbl[i].ba, tbl[i].rdy);
      expect_out($sformatf("table[%0d]", i), tbl[i].ce, tbl[i].ra, tbl[i].vld, tbl[i].pc, tbl[i].inst);
    end
`ifdef FETCH_STATS_EN
    @(negedge clk); #1;
    check("table_fetch_cnt", {96'd0, bus.fetch_cnt_o}, 128'd5);
    check("table_flush_cnt", {96'd0, bus.flush_cnt_o}, 128'd1);
`endif

    // Backpressure: exactly DEPTH issues, then a single credit, then branch over a full queue.
    do_reset();
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (bus.rom_ce_o) issues++;
    end
    check("bp_issue_count", 128'(issues), 128'd4);
    expect_out("bp_full_hold", 1'b0, 32'h10, 1'b1, 32'h0, 32'h100);
    drive(1'b0, 32'h0, 1'b1);
    expect_out("bp_pop_cycle", 1'b0, 32'h10, 1'b1, 32'h0, 32'h100);
    drive(1'b0, 32'h0, 1'b0);
    expect_out("bp_one_issue", 1'b1, 32'h10, 1'b1, 32'h4, 32'h101);
    drive(1'b1, 32'h200, 1'b1);
    expect_out("br_full_cycle", 1'b0, 32'h14, 1'b1, 32'h4, 32'h101);
    drive(1'b0, 32'h0, 1'b1);
    expect_out("br_plus1", 1'b1, 32'h200, 1'b0, 32'h0, NOP);
    drive(1'b0, 32'h0, 1'b1);
    expect_out("br_plus2", 1'b1, 32'h204, 1'b0, 32'h0, NOP);
    drive(1'b0, 32'h0, 1'b1);
    expect_out("br_plus3", 1'b1, 32'h208, 1'b1, 32'h200, 32'h180);

    // Address wrap on the second instance.
    do_reset();
    drive(1'b0, 32'h0, 1'b1);
    check("wrap_addr0", {95'd0, bus2.rom_ce_o, bus2.rom_addr_o}, {95'd0, 1'b1, 32'hFFFF_FFFC});
    drive(1'b0, 32'h0, 1'b1);
    check("wrap_addr1", {95'd0, bus2.rom_ce_o, bus2.rom_addr_o}, {95'd0, 1'b1, 32'h0});
    drive(1'b0, 32'h0, 1'b1);
    check("wrap_head", {63'd0, bus2.id_valid_o, bus2.id_pc_o, bus2.id_inst_o},
                       {63'd0, 1'b1, 32'hFFFF_FFFC, 32'h4000_00FF});

    // Reset mid-operation: 3 entries queued and a read in flight.
    do_reset();
    repeat (4) drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    expect_out("pre_rst_state", 1'b0, 32'h10, 1'b1, 32'h0, 32'h100);
    rst = 1'b1;
    #1;
    expect_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
`ifdef FETCH_STATS_EN
    check("rst_stats", {64'd0, bus.fetch_cnt_o, bus.flush_cnt_o}, 128'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    expect_out("restart_c0", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
    drive(1'b0, 32'h0, 1'b1);
    expect_out("restart_c1", 1'b1, 32'h4, 1'b0, 32'h0, NOP);
    drive(1'b0, 32'h0, 1'b1);
    expect_out("restart_c2", 1'b1, 32'h8, 1'b1, 32'h0, 32'h100);

    // Randomized run against the reference model.
    do_reset();
    mq.delete();
    m_fpc = 32'h0; m_pend = 1'b0; m_pend_pc = 32'h0; m_pops = 0; m_flushes = 0;
    for (int i = 0; i < 600; i++) begin
      model_step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 9) < 6, "random");
    end
`ifdef FETCH_STATS_EN
    @(negedge clk); #1;
    check("rand_fetch_cnt", {96'd0, bus.fetch_cnt_o}, 128'(m_pops));
    check("rand_flush_cnt", {96'd0, bus.flush_cnt_o}, 128'(m_flushes));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised fetch stage that replaces the fixed pc register plus IF/ID register pair.
- Issues sequential instruction-ROM reads ahead of decode and buffers returned {pc, inst} pairs in a DEPTH-entry FIFO.
- Presents a valid/ready interface to ID and flushes cleanly on an ID-stage branch.
- Sits between the instruction ROM and the ID stage, so decode can stall without losing fetched instructions.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- branch_flag_i  in  1  ID redirect request.
- branch_addr_i  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0.
- rom_addr_o  out  ADDR_W  ROM read address.
- rom_ce_o  out  1  ROM read enable.
- rom_data_i  in  DATA_W  ROM data, valid exactly 1 cycle after a cycle with rom_ce_o=1.
- id_ready_i  in  1  ID accepts the head entry this cycle.
- id_valid_o  out  1  head entry valid.
- id_pc_o  out  ADDR_W  head pc.
- id_inst_o  out  DATA_W  head instruction.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC, FIFO empty, inflight=0.
  - rom_ce_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=32'h0000_0013 (NOP).
- Issue:
  - issue = !branch_flag_i && (count + inflight) < DEPTH, using registered count and inflight.
  - rom_ce_o=issue; rom_addr_o=fetch_pc.
  - On issue: fetch_pc += 4 (wraps modulo 2^ADDR_W), inflight<=1, inflight_pc<=fetch_pc.
  - With no issue: inflight<=0.
- Return: in the cycle after an issue, {inflight_pc, rom_data_i} is written at the FIFO write pointer, unless a flush occurs in that same cycle.
- Pop: pop = id_valid_o && id_ready_i; the read pointer advances.
  - id_valid_o = (count != 0).
  - id_pc_o/id_inst_o show the head entry. When empty they show 0 / NOP.
- Count:
  - count_next = count + push - pop.
  - Push and pop may occur in the same cycle, including when count==DEPTH-1.
  - Credits freed by a pop take effect the following cycle.
  - Overflow is impossible by construction.
- Flush (branch_flag_i=1):
  - A pop in the same cycle still occurs; the branch instruction itself is consumed.
  - All FIFO entries are discarded: count<=0, pointers<=0.
  - Any return arriving this cycle is dropped; inflight<=0.
  - No issue this cycle; fetch_pc<={branch_addr_i[ADDR_W-1:2],2'b00}.
  - The first fetch of the target is issued the next cycle.
- Latency:
  - First issue occurs in the first cycle after reset release.
  - That data is pushed 1 cycle later and id_valid_o rises 2 cycles after the issue.
  - Steady state: one instruction per cycle while id_ready_i=1.
  - Branch penalty: target reaches id_valid_o 3 cycles after the branch cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Reset asserted mid-operation immediately clears everything, including in-flight data; any ROM data in the next cycle is ignored.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, two ports are added: fetch_cnt_o out 32 and flush_cnt_o out 32.
  - fetch_cnt_o counts pops; flush_cnt_o counts cycles with branch_flag_i=1 that discarded ≥1 entry or an in-flight read.
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and update 1 cycle after the event.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0, id_ready_i=1, ROM mem[n]=n+0x100:
  - rom_addr_o is 0,4,8,... on consecutive cycles.
  - id_valid_o rises at cycle 2.
  - id_pc_o/id_inst_o are 0/0x100, then 4/0x101, ... with no gaps.
- Backpressure, DEPTH=4, id_ready_i=0:
  - Exactly 4 issues, then rom_ce_o=0 and id_valid_o stays 1.
  - After id_ready_i=1 for one cycle, exactly one new issue occurs the following cycle.
- Branch with full FIFO and a read in flight, branch_addr_i=0x200:
  - The head is popped that cycle; all others are discarded and the in-flight data is dropped.
  - No issue that cycle; rom_addr_o=0x200 next cycle.
  - id_pc_o=0x200 appears 3 cycles after the branch.
- Misaligned target branch_addr_i=0x20B -> fetch address 0x208.
- Address wrap with RESET_PC=32'hFFFF_FFFC -> fetch addresses FFFF_FFFC then 0000_0000.
- rst asserted while FIFO holds 3 entries and a read is in flight:
  - Outputs return to reset values asynchronously.
  - After release the fetch restarts at RESET_PC.
  - With FETCH_STATS_EN, both counters read 0.
